// File: rtl/isa_pkg.sv
// Shared ISA definitions for the execute stage: widths, ALU op codes,
// writeback-select encoding, multiplier FSM states and a small decode helper.
package isa_pkg;

    localparam int DATA_WIDTH = 19;
    localparam int PC_WIDTH   = 15;
    localparam int REG_WIDTH  = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC1 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    // A bubble (no register write) must never launch a multiply.
    function automatic logic mul_request(input logic [2:0] op, input logic reg_write);
        return (op == ALU_MUL) && reg_write;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W
// bits of the product kept in the accumulator.
module mul_iter
    import isa_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    mul_state_t        state_r;
    mul_state_t        state_s;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] acc_r;
    logic [4:0]        count_r;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= MUL_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and start decode.
    always_comb begin
        state_s = state_r;
        start   = 1'b0;
        case (state_r)
            MUL_IDLE: begin
                if (req) begin
                    start   = 1'b1;
                    state_s = MUL_BUSY;
                end else begin
                    state_s = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                if (count_r == 5'(DATA_W - 1)) begin
                    state_s = MUL_DONE;
                end else begin
                    state_s = MUL_BUSY;
                end
            end
            MUL_DONE: state_s = MUL_IDLE;
            default:  state_s = MUL_IDLE;
        endcase
    end

    // Operand shift registers, accumulator and step counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r     <= {DATA_W{1'b0}};
            b_r     <= {DATA_W{1'b0}};
            acc_r   <= {DATA_W{1'b0}};
            count_r <= 5'd0;
        end else if (start) begin
            a_r     <= src_a;
            b_r     <= src_b;
            acc_r   <= {DATA_W{1'b0}};
            count_r <= 5'd0;
        end else if (busy) begin
            // Bits of a_r shifted past DATA_W cannot reach the kept product.
            if (b_r[0]) begin
                acc_r <= acc_r + a_r;
            end else begin
                acc_r <= acc_r;
            end
            a_r     <= a_r << 1;
            b_r     <= b_r >> 1;
            count_r <= count_r + 5'd1;
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

    assign busy    = (state_r == MUL_BUSY);
    assign done    = (state_r == MUL_DONE);
    assign product = acc_r;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch/jump resolution, iterative MUL control and the
// EX/MEM pipeline register.
module execute_stage
    import isa_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int PC_W   = PC_WIDTH,
    parameter int REG_W  = REG_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              JumpE,
    input  logic              BranchE,
    input  logic              ALUSrcE,
    input  logic [1:0]        ResultSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] ImmExtE,
    input  logic [PC_W-1:0]   PCE,
    input  logic [REG_W-1:0]  RDE,
    output logic              PCSrcE,
    output logic [PC_W-1:0]   PCTargetE,
    output logic              StallE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [PC_W-1:0]   PCPlus1M,
    output logic [REG_W-1:0]  RdM
);

    logic [DATA_W-1:0] src_a_s;
    logic [DATA_W-1:0] src_b_s;
    logic [4:0]        shamt_s;
    logic [DATA_W-1:0] alu_result_s;
    logic [DATA_W-1:0] ex_result_s;
    logic              zero_s;
    logic              mul_req_s;
    logic              mul_start_s;
    logic              mul_busy_s;
    logic              mul_done_s;
    logic [DATA_W-1:0] mul_product_s;
    logic              idle_s;
    logic              stall_s;

    assign src_a_s   = RD1E;
    assign src_b_s   = ALUSrcE ? ImmExtE : RD2E;
    assign shamt_s   = src_b_s[4:0];
    assign mul_req_s = mul_request(ALUControlE, RegWriteE);

    mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .req     (mul_req_s),
        .src_a   (src_a_s),
        .src_b   (src_b_s),
        .start   (mul_start_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Single-cycle ALU; MUL produces its result through the iterative unit.
    always_comb begin
        alu_result_s = {DATA_W{1'b0}};
        case (alu_op_t'(ALUControlE))
            ALU_ADD: alu_result_s = src_a_s + src_b_s;
            ALU_SUB: alu_result_s = src_a_s - src_b_s;
            ALU_AND: alu_result_s = src_a_s & src_b_s;
            ALU_OR:  alu_result_s = src_a_s | src_b_s;
            ALU_XOR: alu_result_s = src_a_s ^ src_b_s;
            ALU_SLL: begin
                if (shamt_s >= 5'(DATA_W)) begin
                    alu_result_s = {DATA_W{1'b0}};
                end else begin
                    alu_result_s = src_a_s << shamt_s;
                end
            end
            ALU_SRL: begin
                if (shamt_s >= 5'(DATA_W)) begin
                    alu_result_s = {DATA_W{1'b0}};
                end else begin
                    alu_result_s = src_a_s >> shamt_s;
                end
            end
            ALU_MUL: alu_result_s = {DATA_W{1'b0}};
            default: alu_result_s = {DATA_W{1'b0}};
        endcase
    end

    assign zero_s      = (alu_result_s == {DATA_W{1'b0}});
    assign idle_s      = ~mul_busy_s & ~mul_done_s;
    assign PCSrcE      = idle_s & (JumpE | (BranchE & zero_s));
    assign PCTargetE   = PCE + ImmExtE[PC_W-1:0];
    // Gated by reset so the hold releases the instant reset asserts.
    assign stall_s     = reset & (mul_start_s | mul_busy_s);
    assign StallE      = stall_s;
    assign ex_result_s = mul_done_s ? mul_product_s : alu_result_s;

    // EX/MEM pipeline register: bubble while stalled, product on MUL completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            ALUResultM <= {DATA_W{1'b0}};
            WriteDataM <= {DATA_W{1'b0}};
            PCPlus1M   <= {PC_W{1'b0}};
            RdM        <= {REG_W{1'b0}};
        end else if (stall_s) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            ALUResultM <= {DATA_W{1'b0}};
            WriteDataM <= {DATA_W{1'b0}};
            PCPlus1M   <= {PC_W{1'b0}};
            RdM        <= {REG_W{1'b0}};
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            ALUResultM <= ex_result_s;
            WriteDataM <= RD2E;
            PCPlus1M   <= PCE + {{(PC_W-1){1'b0}}, 1'b1};
            RdM        <= RDE;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed scoreboard bench for execute_stage: the driver queues expected
// EX/MEM contents, a monitor pops and compares on each non-bubble writeback.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [18:0] RD1E, RD2E, ImmExtE;
    logic [14:0] PCE;
    logic [4:0]  RDE;
    logic        PCSrcE, StallE, RegWriteM, MemWriteM;
    logic [14:0] PCTargetE, PCPlus1M;
    logic [1:0]  ResultSrcM;
    logic [18:0] ALUResultM, WriteDataM;
    logic [4:0]  RdM;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [18:0] alu;
        logic [18:0] wd;
        logic [14:0] pc1;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .RDE(RDE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallE(StallE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus1M(PCPlus1M), .RdM(RdM)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] op, input logic [18:0] a, input logic [18:0] b,
                          input logic [18:0] imm, input logic src, input logic [14:0] pc,
                          input logic [4:0] rd, input logic rw, input logic mw,
                          input logic [1:0] rs, input logic br, input logic jp);
        ALUControlE = op;  RD1E = a;  RD2E = b;  ImmExtE = imm;  ALUSrcE = src;
        PCE = pc;  RDE = rd;  RegWriteE = rw;  MemWriteE = mw;  ResultSrcE = rs;
        BranchE = br;  JumpE = jp;
    endtask

    task automatic bubble();
        set_in(3'b000, 19'd0, 19'd0, 19'd0, 1'b0, 15'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // Drive one instruction into EX; MULs are followed through their stall window.
    task automatic issue(input string name, input logic [2:0] op, input logic [18:0] a,
                         input logic [18:0] b, input logic [18:0] imm, input logic src,
                         input logic [14:0] pc, input logic [4:0] rd, input logic rw,
                         input logic mw, input logic [1:0] rs, input logic br, input logic jp,
                         input logic [18:0] exp_alu, input logic exp_pcsrc,
                         input logic [14:0] exp_tgt);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        set_in(op, a, b, imm, src, pc, rd, rw, mw, rs, br, jp);
        if (rw | mw) begin
            e.rw = rw;  e.mw = mw;  e.rs = rs;  e.alu = exp_alu;  e.wd = b;
            e.pc1 = pc + 15'd1;  e.rd = rd;
            sb_q.push_back(e);
        end
        #1;
        check({name, "_pcsrc"}, PCSrcE, exp_pcsrc);
        if (exp_pcsrc) check({name, "_target"}, PCTargetE, exp_tgt);
        if (op == 3'b111 && rw) begin
            n = 0;
            while (StallE === 1'b1 && n < 40) begin
                n++;
                @(posedge clk); #1;
            end
            check({name, "_stall_cycles"}, n, 20);
        end else begin
            check({name, "_stall"}, StallE, 1'b0);
        end
    endtask

    // Monitor: every non-bubble EX/MEM entry must match the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && (RegWriteM | MemWriteM)) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_writeback: got alu 0x%0h rd %0d, expected none",
                             ALUResultM, RdM);
                end else begin
                    e = sb_q.pop_front();
                    check("m_alu", ALUResultM, e.alu);
                    check("m_fields", {RegWriteM, MemWriteM, ResultSrcM, WriteDataM, PCPlus1M, RdM},
                          {e.rw, e.mw, e.rs, e.wd, e.pc1, e.rd});
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1'b0;
        bubble();
        repeat (2) @(posedge clk);
        #1;
        set_in(3'b111, 19'd3, 19'd4, 19'd0, 1'b0, 15'd0, 5'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        #1;
        check("rst_alu", ALUResultM, 19'd0);
        check("rst_fields", {RegWriteM, MemWriteM, ResultSrcM, WriteDataM, PCPlus1M, RdM}, 64'd0);
        check("rst_stall", StallE, 1'b0);
        bubble();
        @(negedge clk) reset = 1'b1;

        // Reset asserted mid-stream with a valid entry in EX/MEM and a MUL pending.
        issue("pre", 3'b000, 19'd1, 19'd1, 19'd0, 1'b0, 15'd3, 5'd3, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'd2, 1'b0, 15'd0);
        @(posedge clk); #1;
        set_in(3'b111, 19'd3, 19'd4, 19'd0, 1'b0, 15'd4, 5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        sb_q.delete();
        #1;
        check("rstmid_alu", ALUResultM, 19'd0);
        check("rstmid_fields", {RegWriteM, MemWriteM, ResultSrcM, WriteDataM, PCPlus1M, RdM}, 64'd0);
        check("rstmid_stall", StallE, 1'b0);
        repeat (2) @(posedge clk);
        bubble();
        @(negedge clk) reset = 1'b1;

        issue("add", 3'b000, 19'd5, 19'd7, 19'd0, 1'b0, 15'd20, 5'd1, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'd12, 1'b0, 15'd0);
        @(posedge clk); #1;
        check("add_latency", ALUResultM, 19'd12);
        bubble();
        issue("sub", 3'b001, 19'd0, 19'd1, 19'd0, 1'b0, 15'd21, 5'd2, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'h7FFFF, 1'b0, 15'd0);
        issue("sll", 3'b101, 19'd1, 19'd18, 19'd0, 1'b0, 15'd22, 5'd3, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'h40000, 1'b0, 15'd0);
        issue("srl19", 3'b110, 19'h7FFFF, 19'd19, 19'd0, 1'b0, 15'd23, 5'd4, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'd0, 1'b0, 15'd0);
        issue("and", 3'b010, 19'h0F0F0, 19'd0, 19'h00FF0, 1'b1, 15'd24, 5'd5, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'h000F0, 1'b0, 15'd0);
        issue("or", 3'b011, 19'h0F000, 19'h000F0, 19'd0, 1'b0, 15'd25, 5'd6, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'h0F0F0, 1'b0, 15'd0);
        issue("xor", 3'b100, 19'h7FFFF, 19'h0000F, 19'd0, 1'b0, 15'd26, 5'd7, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'h7FFF0, 1'b0, 15'd0);
        issue("store", 3'b000, 19'd16, 19'h01234, 19'd4, 1'b1, 15'd27, 5'd0, 1'b0, 1'b1, 2'b00,
              1'b0, 1'b0, 19'd20, 1'b0, 15'd0);
        issue("beq_t", 3'b001, 19'd9, 19'd9, 19'h7FFFE, 1'b0, 15'd100, 5'd0, 1'b0, 1'b0, 2'b00,
              1'b1, 1'b0, 19'd0, 1'b1, 15'd98);
        issue("beq_nt", 3'b001, 19'd9, 19'd8, 19'h7FFFE, 1'b0, 15'd100, 5'd0, 1'b0, 1'b0, 2'b00,
              1'b1, 1'b0, 19'd1, 1'b0, 15'd0);
        issue("jal", 3'b000, 19'd0, 19'd0, 19'd5, 1'b0, 15'd10, 5'd1, 1'b1, 1'b0, 2'b10,
              1'b0, 1'b1, 19'd0, 1'b1, 15'd15);
        issue("mul1", 3'b111, 19'd300, 19'd400, 19'd0, 1'b0, 15'd30, 5'd8, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'd120000, 1'b0, 15'd0);
        issue("mul_max", 3'b111, 19'h7FFFF, 19'h7FFFF, 19'd0, 1'b0, 15'd31, 5'd9, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'd1, 1'b0, 15'd0);
        issue("mul_b2b_a", 3'b111, 19'd123, 19'd45, 19'd0, 1'b0, 15'd32, 5'd10, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'd5535, 1'b0, 15'd0);
        issue("mul_b2b_b", 3'b111, 19'd1000, 19'd0, 19'd1000, 1'b1, 15'd33, 5'd11, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'd475712, 1'b0, 15'd0);

        // Reset pulsed while the multiplier is at BUSY step 10: no result may emerge.
        @(posedge clk); #1;
        set_in(3'b111, 19'd7, 19'd9, 19'd0, 1'b0, 15'd40, 5'd12, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        #1;
        check("rmul_detect", StallE, 1'b1);
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rmul_stall", StallE, 1'b0);
        check("rmul_regwrite", RegWriteM, 1'b0);
        bubble();
        @(negedge clk) reset = 1'b1;
        issue("post_rst", 3'b000, 19'd2, 19'd3, 19'd0, 1'b0, 15'd41, 5'd13, 1'b1, 1'b0, 2'b00,
              1'b0, 1'b0, 19'd5, 1'b0, 15'd0);
        @(posedge clk); #1;
        bubble();
        repeat (25) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage pipeline. It sits between the ID/EX register and the MEM stage and consumes every E-suffixed control and data field that decode registers. It performs ALU operations, including an iterative multi-cycle MUL, and resolves branches and jumps toward fetch. Results go into the EX/MEM pipeline register, whose contents it drives as the M-suffixed outputs.

## Interface
Parameters:
- DATA_W, 19, register/data width
- PC_W, 15, program counter width
- REG_W, 5, register address width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; one clock, reset asynchronous and active-low
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1 each  control fields from ID/EX
- ResultSrcE  in  2  writeback select, passed through
- ALUControlE  in  3  ALU operation
- RD1E, RD2E, ImmExtE  in  DATA_W  source operands, extended immediate
- PCE  in  PC_W  instruction PC
- RDE  in  REG_W  destination register
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  PC_W  branch/jump target (combinational)
- StallE  out  1  hold fetch/decode/ID-EX (combinational)
- RegWriteM, MemWriteM  out  1  EX/MEM control
- ResultSrcM  out  2  EX/MEM writeback select
- ALUResultM, WriteDataM  out  DATA_W  ALU result, store data (RD2E)
- PCPlus1M  out  PC_W  PCE+1 for link writeback
- RdM  out  REG_W  EX/MEM destination

## Operation
- SrcB = ALUSrcE ? ImmExtE : RD2E; SrcA = RD1E.
- ALUControlE values: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL (logical), 111 MUL.
- All arithmetic is mod 2^DATA_W.
- Shift amount is SrcB[4:0]; amounts ≥19 yield 0.
- MUL returns the low 19 bits of SrcA*SrcB.
- ZeroE = (ALU result == 0).
- PCSrcE = JumpE | (BranchE & ZeroE).
- PCTargetE = PCE + ImmExtE[PC_W-1:0], mod 2^15.
- PCSrcE is forced to 0 when state ≠ IDLE.
- MUL start condition: state IDLE, ALUControlE==111 and RegWriteE==1. A bubble (RegWriteE=0) never starts MUL.
- FSM states:
  - IDLE: non-MUL instructions complete in one cycle. On start, latch SrcA/SrcB, clear accumulator, count←0, go BUSY.
  - BUSY: one shift-add step per cycle. At count==18, go DONE.
  - DONE: result valid, go IDLE.
- StallE = (IDLE & start) | BUSY.
- While StallE=1, EX/MEM captures a bubble: RegWriteM=MemWriteM=0, ResultSrcM=0, data fields 0.
- In DONE, EX/MEM captures the product plus the held ID/EX control fields. Upstream holds ID/EX stable during the stall.
- EX/MEM otherwise captures every cycle: RegWriteE, MemWriteE, ResultSrcE, ALU result, RD2E, PCE+1, RDE.

## Timing
- Reset (async, active-low): EX/MEM cleared to all zeros, i.e. every M output is 0; FSM to IDLE; count 0; accumulator 0.
- Reset mid-MUL abandons the operation with no partial write. StallE drops to 0 as soon as reset asserts.
- Non-MUL latency: 1 cycle. Inputs at edge n appear on M outputs after edge n+1.
- MUL timing:
  - StallE is high for 20 cycles: the detect cycle plus 19 BUSY cycles.
  - The DONE cycle has StallE=0, and the result is registered at the end of DONE.
  - Total occupancy is 21 cycles.
- PCSrcE/PCTargetE are valid in the same cycle the branch sits in EX. Flushing younger stages belongs to the hazard unit.
- Back-to-back MULs: the DONE→IDLE cycle sees the next instruction, so a second MUL starts in that IDLE cycle with no gap cycle.

## Structure
- Shared package isa_pkg: DATA_W/PC_W/REG_W constants, alu_op_t enum for the 3-bit ALUControl codes, ResultSrc encoding (00 ALU, 01 memory, 10 PC+1).
- Sub-module mul_iter: shift-add multiplier with start/busy/done, 5-bit counter, and DATA_W accumulator truncated to DATA_W.
- ALU, branch logic and EX/MEM register live in execute_stage.

## Test plan
- Reset asserted mid-stream -> all M outputs 0, StallE 0; after release, ADD RD1E=5, RD2E=7 -> ALUResultM=12 one cycle later.
- SUB 0 - 1 -> ALUResultM=0x7FFFF. SLL 1 by 18 -> 0x40000. SRL by 19 -> 0.
- BEQ: BranchE=1, SUB RD1E=RD2E=9, PCE=100, ImmExtE=0x7FFFE -> PCSrcE=1, PCTargetE=98. With RD2E=8 -> PCSrcE=0.
- MUL 300*400 -> StallE high 20 cycles, bubbles in EX/MEM, then ALUResultM=120000 mod 2^19=120000, RegWriteM=1.
- MUL 0x7FFFF*0x7FFFF -> ALUResultM=1.
- Reset pulsed at BUSY count 10 -> state IDLE, StallE 0, RegWriteM 0, no result issued.
- Two consecutive MULs -> two 20-cycle stall windows separated by exactly one DONE cycle, both products correct.
